alu_seq: RTL and testbench



---
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_seq.sv | 275 +++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - command/result handshake bundle between operand fetch, alu_seq and write-back
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  // command side: operands and opcode offered by operand fetch
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       f;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  // result side: registered result and status towards write-back
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             zero;
  logic             neg;
  logic             err;

  // producer of commands / consumer of results
  modport master (
    output in_valid, f, a, b, out_ready,
    input  in_ready, out_valid, s, zero, neg, err
  );

  // the ALU itself
  modport slave (
    input  in_valid, f, a, b, out_ready,
    output in_ready, out_valid, s, zero, neg, err
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked sequential ALU, s = b OP a; ALU_SEQ_DIV_EN adds iterative DIV/MOD
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_SHL  = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_BAND = 5'd5;
  localparam logic [4:0] OP_BOR  = 5'd6;
  localparam logic [4:0] OP_BXOR = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_EQ   = 5'd10;
  localparam logic [4:0] OP_NE   = 5'd11;
  localparam logic [4:0] OP_GE   = 5'd12;
  localparam logic [4:0] OP_LE   = 5'd13;
  localparam logic [4:0] OP_GT   = 5'd14;
  localparam logic [4:0] OP_LT   = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_BNOT = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [4:0] OP_DIV  = 5'd19;
  localparam logic [4:0] OP_MOD  = 5'd20;
`endif

  // shift amounts at or above this limit flush the result to zero
  localparam logic [WIDTH-1:0] SH_LIM   = WIDTH'(WIDTH);
  // counter value during the final iteration of a multi-cycle op
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_nxt;

  // iteration registers shared by multiplier and divider:
  //   MUL: acc = partial product, mc = multiplicand shifted left, mp = multiplier shifted right
  //   DIV: acc = partial remainder, mc = |divisor|, mp = dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mc;
  logic [WIDTH-1:0] mp;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mc_nxt;
  logic [WIDTH-1:0] mp_nxt;

`ifdef ALU_SEQ_DIV_EN
  // operation context captured at accept for the divider's final sign fix-up
  logic [4:0]       op_f;
  logic             div_zero;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] b_raw;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_dif;
`endif

  // registered result and flags
  logic [WIDTH-1:0] s_q;
  logic             zero_q;
  logic             neg_q;
  logic             err_q;

  logic             accept;
  logic             is_multi;
  logic             last_step;
  logic [WIDTH-1:0] sc_res;
  logic             sc_err;
  logic [WIDTH-1:0] fin_res;
  logic             fin_err;

  function automatic logic [WIDTH-1:0] bool2w(input logic x);
    return {{(WIDTH-1){1'b0}}, x};
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? ('0 - x) : x;
  endfunction

  assign accept    = bus.in_valid && (state == IDLE);
  assign last_step = (cnt == LAST_CNT);

  assign bus.s    = s_q;
  assign bus.zero = zero_q;
  assign bus.neg  = neg_q;
  assign bus.err  = err_q;

  // which opcodes take the iterative path instead of completing in one cycle
  always_comb begin
    is_multi = (bus.f == OP_MUL);
`ifdef ALU_SEQ_DIV_EN
    if ((bus.f == OP_DIV) || (bus.f == OP_MOD)) begin
      is_multi = 1'b1;
    end
`endif
  end

  // single-cycle result straight from the live operands; unknown opcodes raise err with s = 0
  always_comb begin
    sc_res = '0;
    sc_err = 1'b0;
    case (bus.f)
      OP_ADD:  sc_res = bus.b + bus.a;
      OP_SUB:  sc_res = bus.b - bus.a;
      OP_MUL:  sc_res = '0;
      OP_SHL:  sc_res = (bus.a >= SH_LIM) ? '0 : (bus.b << bus.a);
      OP_SHR:  sc_res = (bus.a >= SH_LIM) ? '0 : (bus.b >> bus.a);
      OP_BAND: sc_res = bus.b & bus.a;
      OP_BOR:  sc_res = bus.b | bus.a;
      OP_BXOR: sc_res = bus.b ^ bus.a;
      OP_AND:  sc_res = bool2w((bus.b != '0) && (bus.a != '0));
      OP_OR:   sc_res = bool2w((bus.b != '0) || (bus.a != '0));
      OP_EQ:   sc_res = bool2w(bus.b == bus.a);
      OP_NE:   sc_res = bool2w(bus.b != bus.a);
      OP_GE:   sc_res = bool2w($signed(bus.b) >= $signed(bus.a));
      OP_LE:   sc_res = bool2w($signed(bus.b) <= $signed(bus.a));
      OP_GT:   sc_res = bool2w($signed(bus.b) > $signed(bus.a));
      OP_LT:   sc_res = bool2w($signed(bus.b) < $signed(bus.a));
      OP_NEG:  sc_res = '0 - bus.a;
      OP_BNOT: sc_res = ~bus.a;
      OP_NOT:  sc_res = bool2w(bus.a == '0);
`ifdef ALU_SEQ_DIV_EN
      OP_DIV:  sc_res = '0;
      OP_MOD:  sc_res = '0;
`endif
      default: sc_err = 1'b1;
    endcase
  end

  // one iteration: shift-add for MUL, restoring-divide step on magnitudes for DIV/MOD
  always_comb begin
    acc_nxt = mp[0] ? (acc + mc) : acc;
    mc_nxt  = mc << 1;
    mp_nxt  = mp >> 1;
`ifdef ALU_SEQ_DIV_EN
    rem_sh  = {acc, mp[WIDTH-1]};
    rem_dif = rem_sh - {1'b0, mc};
    if (op_f != OP_MUL) begin
      mc_nxt = mc;
      if (!rem_dif[WIDTH]) begin
        acc_nxt = rem_dif[WIDTH-1:0];
        mp_nxt  = {mp[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = rem_sh[WIDTH-1:0];
        mp_nxt  = {mp[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // result of the last iteration, with sign restoration and divide-by-zero override for DIV/MOD
  always_comb begin
    fin_res = acc_nxt;
    fin_err = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    if (op_f == OP_DIV) begin
      fin_res = div_zero ? '1 : (q_neg ? ('0 - mp_nxt) : mp_nxt);
      fin_err = div_zero;
    end else if (op_f == OP_MOD) begin
      fin_res = div_zero ? b_raw : (r_neg ? ('0 - acc_nxt) : acc_nxt);
      fin_err = div_zero;
    end
`endif
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state and handshake outputs; a result is never overlapped with the next accept
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (accept) begin
          state_nxt = is_multi ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // datapath: load at accept, iterate while busy, hold the result untouched while done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      mc       <= '0;
      mp       <= '0;
      cnt      <= '0;
      s_q      <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      op_f     <= '0;
      div_zero <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      b_raw    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            acc <= '0;
            mc  <= bus.b;
            mp  <= bus.a;
`ifdef ALU_SEQ_DIV_EN
            op_f     <= bus.f;
            div_zero <= (bus.a == '0);
            q_neg    <= bus.b[WIDTH-1] ^ bus.a[WIDTH-1];
            r_neg    <= bus.b[WIDTH-1];
            b_raw    <= bus.b;
            if ((bus.f == OP_DIV) || (bus.f == OP_MOD)) begin
              mc <= mag(bus.a);
              mp <= mag(bus.b);
            end
`endif
            if (!is_multi) begin
              s_q    <= sc_res;
              zero_q <= (sc_res == '0);
              neg_q  <= sc_res[WIDTH-1];
              err_q  <= sc_err;
            end
          end
        end
        BUSY: begin
          acc <= acc_nxt;
          mc  <= mc_nxt;
          mp  <= mp_nxt;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            s_q    <= fin_res;
            zero_q <= (fin_res == '0);
            neg_q  <= fin_res[WIDTH-1];
            err_q  <= fin_err;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq: vector table, corner sequences, random vs model
module tb_alu_seq;

  localparam int W = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] f;
    logic [W-1:0] b;
    logic [W-1:0] a;
    logic [W-1:0] s;
    logic       err;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // reference behaviour from the opcode definitions, in plain integer arithmetic
  function automatic void model(input logic [4:0] f, input logic [W-1:0] b, input logic [W-1:0] a,
                                output logic [W-1:0] r, output logic e, output int lat);
    int     sb;
    int     sa;
    int     ua;
    longint p;
    sb  = $signed(b);
    sa  = $signed(a);
    ua  = int'(a);
    r   = '0;
    e   = 1'b0;
    lat = 1;
    case (f)
      5'd0:  r = W'(sb + sa);
      5'd1:  r = W'(sb - sa);
      5'd2:  begin p = longint'(sb) * longint'(sa); r = p[W-1:0]; lat = W + 1; end
      5'd3:  r = (ua >= W) ? '0 : W'(b << a);
      5'd4:  r = (ua >= W) ? '0 : W'(b >> a);
      5'd5:  r = b & a;
      5'd6:  r = b | a;
      5'd7:  r = b ^ a;
      5'd8:  r = ((sb != 0) && (sa != 0)) ? 1 : 0;
      5'd9:  r = ((sb != 0) || (sa != 0)) ? 1 : 0;
      5'd10: r = (sb == sa) ? 1 : 0;
      5'd11: r = (sb != sa) ? 1 : 0;
      5'd12: r = (sb >= sa) ? 1 : 0;
      5'd13: r = (sb <= sa) ? 1 : 0;
      5'd14: r = (sb > sa) ? 1 : 0;
      5'd15: r = (sb < sa) ? 1 : 0;
      5'd16: r = W'(-sa);
      5'd17: r = ~a;
      5'd18: r = (sa == 0) ? 1 : 0;
`ifdef ALU_SEQ_DIV_EN
      5'd19: begin
        lat = W + 1;
        if (sa == 0) begin r = '1; e = 1'b1; end
        else r = W'(sb / sa);
      end
      5'd20: begin
        lat = W + 1;
        if (sa == 0) begin r = b; e = 1'b1; end
        else r = W'(sb % sa);
      end
`endif
      default: begin r = '0; e = 1'b1; end
    endcase
  endfunction

  // issue one command, measure latency, optionally stall the result for hold cycles
  task automatic do_op(input string name, input logic [4:0] f, input logic [W-1:0] b,
                       input logic [W-1:0] a, input int hold,
                       output logic [W-1:0] rs, output logic rz, output logic rn,
                       output logic re, output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.f         = f;
    bus.b         = b;
    bus.a         = a;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.f = 5'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    rs = bus.s;
    rz = bus.zero;
    rn = bus.neg;
    re = bus.err;
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        @(posedge clk); #1;
        check($sformatf("%s_hold_s", name), 32'(bus.s), 32'(rs));
        check($sformatf("%s_hold_valid", name), 32'(bus.out_valid), 32'd1);
        check($sformatf("%s_hold_ready", name), 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check($sformatf("%s_release_valid", name), 32'(bus.out_valid), 32'd0);
      check($sformatf("%s_release_ready", name), 32'(bus.in_ready), 32'd1);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_vec(input string name, input logic [4:0] f, input logic [W-1:0] b,
                         input logic [W-1:0] a, input logic [W-1:0] xs, input logic xe,
                         input int xlat, input int hold);
    logic [W-1:0] rs;
    logic         rz;
    logic         rn;
    logic         re;
    int           lat;
    do_op(name, f, b, a, hold, rs, rz, rn, re, lat);
    check($sformatf("%s_s", name), 32'(rs), 32'(xs));
    check($sformatf("%s_zero", name), 32'(rz), 32'(xs == '0));
    check($sformatf("%s_neg", name), 32'(rn), 32'(xs[W-1]));
    check($sformatf("%s_err", name), 32'(re), 32'(xe));
    check($sformatf("%s_lat", name), 32'(lat), 32'(xlat));
  endtask

  initial begin
    logic [W-1:0] es;
    logic         ee;
    int           el;
    logic [4:0]   rf;
    logic [W-1:0] rb;
    logic [W-1:0] ra;
    logic         seen;

    n_checks = 0;
    n_fail   = 0;

    vecs.push_back('{"add_cancel", 5'd0,  16'h0007, 16'hFFF9, 16'h0000, 1'b0, 1});
    vecs.push_back('{"sub",        5'd1,  16'h0002, 16'h0005, 16'hFFFD, 1'b0, 1});
    vecs.push_back('{"mul_neg",    5'd2,  16'hFFFD, 16'h0007, 16'hFFEB, 1'b0, 17});
    vecs.push_back('{"mul_wrap",   5'd2,  16'h0100, 16'h0100, 16'h0000, 1'b0, 17});
    vecs.push_back('{"mul_m1sq",   5'd2,  16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 17});
    vecs.push_back('{"shl15",      5'd3,  16'h0001, 16'h000F, 16'h8000, 1'b0, 1});
    vecs.push_back('{"shl16",      5'd3,  16'h0001, 16'h0010, 16'h0000, 1'b0, 1});
    vecs.push_back('{"shr15",      5'd4,  16'h8000, 16'h000F, 16'h0001, 1'b0, 1});
    vecs.push_back('{"shr_big",    5'd4,  16'h8000, 16'h0100, 16'h0000, 1'b0, 1});
    vecs.push_back('{"band",       5'd5,  16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1});
    vecs.push_back('{"bor",        5'd6,  16'hF000, 16'h000F, 16'hF00F, 1'b0, 1});
    vecs.push_back('{"bxor",       5'd7,  16'hF0F0, 16'hFFFF, 16'h0F0F, 1'b0, 1});
    vecs.push_back('{"and0",       5'd8,  16'h0003, 16'h0000, 16'h0000, 1'b0, 1});
    vecs.push_back('{"or1",        5'd9,  16'h0000, 16'h0004, 16'h0001, 1'b0, 1});
    vecs.push_back('{"eq",         5'd10, 16'h0005, 16'h0005, 16'h0001, 1'b0, 1});
    vecs.push_back('{"ne",         5'd11, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1});
    vecs.push_back('{"ge_signed",  5'd12, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1});
    vecs.push_back('{"le_minmax",  5'd13, 16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1});
    vecs.push_back('{"gt_signed",  5'd14, 16'h0001, 16'hFFFF, 16'h0001, 1'b0, 1});
    vecs.push_back('{"lt_signed",  5'd15, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1});
    vecs.push_back('{"neg",        5'd16, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1});
    vecs.push_back('{"bnot",       5'd17, 16'h0000, 16'h00FF, 16'hFF00, 1'b0, 1});
    vecs.push_back('{"not0",       5'd18, 16'h1234, 16'h0000, 16'h0001, 1'b0, 1});
    vecs.push_back('{"not5",       5'd18, 16'h1234, 16'h0005, 16'h0000, 1'b0, 1});
    vecs.push_back('{"ill31",      5'd31, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1});
    vecs.push_back('{"ill21",      5'd21, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1});
`ifdef ALU_SEQ_DIV_EN
    vecs.push_back('{"div_neg",    5'd19, 16'hFFF9, 16'h0002, 16'hFFFD, 1'b0, 17});
    vecs.push_back('{"mod_neg",    5'd20, 16'hFFF9, 16'h0002, 16'hFFFF, 1'b0, 17});
    vecs.push_back('{"div_zero",   5'd19, 16'h0005, 16'h0000, 16'hFFFF, 1'b1, 17});
    vecs.push_back('{"mod_zero",   5'd20, 16'h0005, 16'h0000, 16'h0005, 1'b1, 17});
    vecs.push_back('{"div_min",    5'd19, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 17});
`else
    vecs.push_back('{"ill19",      5'd19, 16'hFFF9, 16'h0002, 16'h0000, 1'b1, 1});
    vecs.push_back('{"ill20",      5'd20, 16'hFFF9, 16'h0002, 16'h0000, 1'b1, 1});
`endif

    bus.in_valid  = 1'b0;
    bus.f         = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_s",         32'(bus.s),         32'd0);
    check("rst_zero",      32'(bus.zero),      32'd0);
    check("rst_neg",       32'(bus.neg),       32'd0);
    check("rst_err",       32'(bus.err),       32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_vec(vecs[i].name, vecs[i].f, vecs[i].b, vecs[i].a, vecs[i].s, vecs[i].err, vecs[i].lat, 0);
    end

    // reset in the middle of a multiply discards it
    bus.f        = 5'd2;
    bus.b        = 16'h0003;
    bus.a        = 16'h0005;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("busy_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_s",         32'(bus.s),         32'd0);
    @(posedge clk); #1;
    check("rst_next_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_next_out_valid", 32'(bus.out_valid), 32'd0);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("rst_discard", 32'(seen), 32'd0);
    run_vec("post_rst_add", 5'd0, 16'h0007, 16'hFFF9, 16'h0000, 1'b0, 1, 0);

    // result backpressure on single-cycle and multi-cycle ops
    run_vec("bp_sub", 5'd1, 16'h0002, 16'h0005, 16'hFFFD, 1'b0, 1, 5);
    run_vec("bp_mul", 5'd2, 16'hFFFD, 16'h0007, 16'hFFEB, 1'b0, 17, 3);

    for (int i = 0; i < 200; i++) begin
      rf = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(21, 31)) : 5'($urandom_range(0, 20));
      rb = W'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      model(rf, rb, ra, es, ee, el);
      run_vec($sformatf("rnd%0d_f%0d", i, rf), rf, rb, ra, es, ee, el, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
